// File: rtl/soc_simple_de1_soc_keys_pio_if.sv
// Avalon-MM slave port bundle for the keys PIO: register select, write strobe and read data.
interface soc_simple_de1_soc_keys_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_simple_de1_soc_keys_pio.sv
// Memory-mapped input port: per-bit synchronizer, debounce, edge capture and masked level interrupt.
module soc_simple_de1_soc_keys_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic                          clk,
    input  logic                          reset,
    soc_simple_de1_soc_keys_pio_if.slave  bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VALUE;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign deb = sync;
        end else begin : g_deb
            localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          deb_r;
                // The count only advances while sync disagrees with the held level.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt   <= '0;
                        deb_r <= RESET_VALUE[b];
                    end else if (sync[b] == deb_r) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        deb_r <= sync[b];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                assign deb[b] = deb_r;
            end
        end
    endgenerate

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = deb & ~deb_d;
            1:       edge_hit = ~deb & deb_d;
            default: edge_hit = (deb & ~deb_d) | (~deb & deb_d);
        endcase
    end

    assign wr_en = bus.chipselect && !bus.write_n;
    assign clr   = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // A new edge is ORed in after the clear, so set wins on a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_d <= RESET_VALUE;
            mask  <= '0;
            cap   <= '0;
        end else begin
            deb_d <= deb;
            if (wr_en && bus.address == 2'd2) mask <= bus.writedata[WIDTH-1:0];
            cap <= (cap & ~clr) | edge_hit;
        end
    end

    assign irq = |(cap & mask);

    always_comb begin
        rd = '0;
        case (bus.address)
            2'd0:    rd[WIDTH-1:0] = deb;
            2'd2:    rd[WIDTH-1:0] = mask;
            2'd3:    rd[WIDTH-1:0] = cap;
            default: rd = '0;
        endcase
    end

    assign bus.readdata  = rd;
    assign unused_wdata  = ^bus.writedata;

endmodule
